// File: rtl/dsram_ctrl.sv
// Data-memory controller: bridges the core's data port to an external async SRAM via an IDLE/ACCESS/DONE FSM.
// Latency: WAIT_CYCLES+2 stalled core cycles per access; read data is valid in DONE and held until the next read.
// Backpressure: stallreq_o holds the core until DONE. DSRAM_POSTED_WRITE_EN lets writes retire without stalling.
module dsram_ctrl #(
    parameter int DATA_W      = 16,
    parameter int SRAM_AW     = 16,
    parameter int WAIT_CYCLES = 2     // legal range 1..15
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               cpu_ce_i,
    input  logic               cpu_we_i,
    input  logic [DATA_W-1:0]  cpu_addr_i,
    input  logic [DATA_W-1:0]  cpu_data_i,
    output logic [DATA_W-1:0]  cpu_data_o,
    output logic               stallreq_o,
    output logic [SRAM_AW-1:0] sram_addr_o,
    output logic [DATA_W-1:0]  sram_dq_o,
    input  logic [DATA_W-1:0]  sram_dq_i,
    output logic               sram_dq_oe_o,
    output logic               sram_ce_n_o,
    output logic               sram_oe_n_o,
    output logic               sram_we_n_o
);

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        DONE
    } state_t;

    localparam logic [3:0] CNT_LAST = 4'(WAIT_CYCLES);

    state_t             state_q, state_nx;
    logic [3:0]         cnt_q, cnt_nx;
    logic [SRAM_AW-1:0] addr_q, addr_nx;
    logic [DATA_W-1:0]  wdata_q, wdata_nx;
    logic [DATA_W-1:0]  rdata_q;
    logic               we_q, we_nx;
    logic               ce_n_q, oe_n_q, we_n_q, dq_oe_q;
    logic               ce_n_nx, oe_n_nx, we_n_nx, dq_oe_nx;
    logic               stall;
`ifdef DSRAM_POSTED_WRITE_EN
    logic               posted_q, posted_nx;
`endif

    always_comb begin
        state_nx = state_q;
        cnt_nx   = cnt_q;
        addr_nx  = addr_q;
        wdata_nx = wdata_q;
        we_nx    = we_q;
        case (state_q)
            IDLE: begin
                if (cpu_ce_i) begin
                    state_nx = ACCESS;
                    cnt_nx   = 4'd0;
                    addr_nx  = cpu_addr_i[SRAM_AW-1:0];
                    wdata_nx = cpu_data_i;
                    we_nx    = cpu_we_i;
                end
            end
            ACCESS: begin
                if (cnt_q == CNT_LAST) begin
                    state_nx = DONE;
                end else begin
                    cnt_nx = cnt_q + 4'd1;
                end
            end
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Strobes are computed from the next state and registered, so the SRAM pins
    // change only on clock edges and never follow cpu_* combinationally.
    always_comb begin
        ce_n_nx  = 1'b1;
        oe_n_nx  = 1'b1;
        we_n_nx  = 1'b1;
        dq_oe_nx = 1'b0;
        case (state_nx)
            ACCESS: begin
                ce_n_nx = 1'b0;
                if (we_nx) begin
                    dq_oe_nx = 1'b1;
                    we_n_nx  = (cnt_nx == 4'd0);
                end else begin
                    oe_n_nx = 1'b0;
                end
            end
            DONE: begin
                if (we_nx) begin
                    ce_n_nx  = 1'b0;
                    dq_oe_nx = 1'b1;
                end
            end
            default: ;
        endcase
    end

`ifdef DSRAM_POSTED_WRITE_EN
    always_comb begin
        posted_nx = posted_q;
        stall     = 1'b0;
        case (state_q)
            IDLE: begin
                stall = cpu_ce_i & ~cpu_we_i;
                if (cpu_ce_i) begin
                    posted_nx = cpu_we_i;
                end
            end
            // A background write holds off any new request until it is back in IDLE.
            ACCESS:  stall = posted_q ? cpu_ce_i : 1'b1;
            DONE:    stall = posted_q ? cpu_ce_i : 1'b0;
            default: stall = 1'b0;
        endcase
    end
`else
    always_comb begin
        stall = 1'b0;
        case (state_q)
            IDLE:    stall = cpu_ce_i;
            ACCESS:  stall = 1'b1;
            default: stall = 1'b0;
        endcase
    end
`endif

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            addr_q  <= '0;
            wdata_q <= '0;
            we_q    <= 1'b0;
            rdata_q <= '0;
            ce_n_q  <= 1'b1;
            oe_n_q  <= 1'b1;
            we_n_q  <= 1'b1;
            dq_oe_q <= 1'b0;
`ifdef DSRAM_POSTED_WRITE_EN
            posted_q <= 1'b0;
`endif
        end else begin
            state_q <= state_nx;
            cnt_q   <= cnt_nx;
            addr_q  <= addr_nx;
            wdata_q <= wdata_nx;
            we_q    <= we_nx;
            ce_n_q  <= ce_n_nx;
            oe_n_q  <= oe_n_nx;
            we_n_q  <= we_n_nx;
            dq_oe_q <= dq_oe_nx;
`ifdef DSRAM_POSTED_WRITE_EN
            posted_q <= posted_nx;
`endif
            if (state_q == ACCESS && cnt_q == CNT_LAST && !we_q) begin
                rdata_q <= sram_dq_i;
            end
        end
    end

    // Reset is synchronous, but the stall request must already be quiet while it is held.
    assign stallreq_o   = rst & stall;
    assign cpu_data_o   = rdata_q;
    assign sram_addr_o  = addr_q;
    assign sram_dq_o    = wdata_q;
    assign sram_dq_oe_o = dq_oe_q;
    assign sram_ce_n_o  = ce_n_q;
    assign sram_oe_n_o  = oe_n_q;
    assign sram_we_n_o  = we_n_q;

endmodule

// File: tb/tb_dsram_ctrl.sv
// Bench for dsram_ctrl: core-side driver, async SRAM model, and a scoreboard checked at every retired request.
// Latency: expected completion cycles come from an occupancy model of the controller (busy WAIT_CYCLES+3 cycles per access).
// Backpressure: the driver holds each request until stallreq_o drops, like the core does.
module tb_dsram_ctrl;
    localparam int W = 2;
`ifdef DSRAM_POSTED_WRITE_EN
    localparam bit POSTED = 1'b1;
`else
    localparam bit POSTED = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        cpu_ce_i, cpu_we_i;
    logic [15:0] cpu_addr_i, cpu_data_i, cpu_data_o;
    logic        stallreq_o;
    logic [15:0] sram_addr_o, sram_dq_o, sram_dq_i;
    logic        sram_dq_oe_o, sram_ce_n_o, sram_oe_n_o, sram_we_n_o;

    dsram_ctrl #(.DATA_W(16), .SRAM_AW(16), .WAIT_CYCLES(W)) dut (
        .clk         (clk),
        .rst         (rst),
        .cpu_ce_i    (cpu_ce_i),
        .cpu_we_i    (cpu_we_i),
        .cpu_addr_i  (cpu_addr_i),
        .cpu_data_i  (cpu_data_i),
        .cpu_data_o  (cpu_data_o),
        .stallreq_o  (stallreq_o),
        .sram_addr_o (sram_addr_o),
        .sram_dq_o   (sram_dq_o),
        .sram_dq_i   (sram_dq_i),
        .sram_dq_oe_o(sram_dq_oe_o),
        .sram_ce_n_o (sram_ce_n_o),
        .sram_oe_n_o (sram_oe_n_o),
        .sram_we_n_o (sram_we_n_o)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // External async SRAM: combinational read while selected, write on any edge with WE# low.
    logic [15:0] sram_mem  [0:65535];
    logic [15:0] model_mem [0:65535];
    assign sram_dq_i = (!sram_ce_n_o && !sram_oe_n_o) ? sram_mem[sram_addr_o] : 16'hDEAD;
    always @(posedge clk) begin
        if (!sram_ce_n_o && !sram_we_n_o && sram_dq_oe_o) sram_mem[sram_addr_o] <= sram_dq_o;
    end

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    typedef struct {
        logic [15:0] data;
        int          comp;
    } exp_t;

    exp_t        sb[$];
    logic [15:0] wr_addrs[$];
    int          free_at;
    logic [15:0] last_rd;
    logic [4:0]  trace [int];

    // Monitor: a request retires in any cycle where it is presented and not stalled.
    always @(negedge clk) begin
        exp_t e;
        trace[cyc] = {stallreq_o, sram_ce_n_o, sram_oe_n_o, sram_we_n_o, sram_dq_oe_o};
        if (rst && cpu_ce_i && !stallreq_o) begin
            if (sb.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL sb_underflow: unexpected retire at cycle %0d", cyc);
            end else begin
                e = sb.pop_front();
                chk("rdata", {16'h0, cpu_data_o}, {16'h0, e.data});
                chk("done_cycle", cyc, e.comp);
            end
        end
        if (rst && !sram_we_n_o)
            chk("we_pulse_bus", {29'h0, sram_dq_oe_o, sram_oe_n_o, sram_ce_n_o}, 32'h6);
    end

    // Reference: the controller is occupied from acceptance until it re-enters IDLE W+3 cycles later.
    task automatic issue(input logic we, input logic [15:0] a, input logic [15:0] d,
                         output int acc, output int comp);
        exp_t e;
        acc     = (cyc > free_at) ? cyc : free_at;
        comp    = (we && POSTED) ? acc : acc + W + 2;
        free_at = acc + W + 3;
        if (we) begin
            model_mem[a] = d;
            wr_addrs.push_back(a);
        end else begin
            last_rd = model_mem[a];
        end
        e.data = last_rd;
        e.comp = comp;
        sb.push_back(e);
        cpu_ce_i   = 1'b1;
        cpu_we_i   = we;
        cpu_addr_i = a;
        cpu_data_i = d;
    endtask

    task automatic xact(input logic we, input logic [15:0] a, input logic [15:0] d, input bit scramble);
        int acc, comp, n;
        issue(we, a, d, acc, comp);
        n = 0;
        forever begin
            @(negedge clk);
            if (cpu_ce_i && !stallreq_o) break;
            n++;
            if (n > 64) begin
                n_cmp++;
                n_err++;
                $display("FAIL xact_timeout: no retire within 64 cycles (cycle %0d)", cyc);
                break;
            end
            @(posedge clk);
            #1;
            // Once accepted, the controller must work from its latched copy.
            if (scramble && cyc > acc && cyc < comp) begin
                cpu_addr_i = 16'($urandom);
                cpu_data_i = 16'($urandom);
                cpu_we_i   = 1'($urandom);
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        cpu_ce_i = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk_trace(input string name, input int t, input logic we);
        for (int k = 0; k <= W + 3; k++) begin
            bit         in_acc, in_done;
            logic [4:0] exp;
            in_acc  = (k >= 1 && k <= W + 1);
            in_done = (k == W + 2);
            if (we) begin
                exp[4] = POSTED ? 1'b0 : (k <= W + 1);
                exp[3] = !(in_acc || in_done);
                exp[2] = 1'b1;
                exp[1] = !(k >= 2 && k <= W + 1);
                exp[0] = in_acc || in_done;
            end else begin
                exp[4] = (k <= W + 1);
                exp[3] = !in_acc;
                exp[2] = !in_acc;
                exp[1] = 1'b1;
                exp[0] = 1'b0;
            end
            chk($sformatf("%s_strobes_k%0d", name, k), {27'h0, trace[t + k]}, {27'h0, exp});
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int t, acc, comp;
        logic        we;
        logic [15:0] a, d;
        for (int i = 0; i < 65536; i++) begin
            sram_mem[i]  = 16'(i * 7 + 3);
            model_mem[i] = 16'(i * 7 + 3);
        end
        free_at    = 0;
        last_rd    = 16'h0;
        rst        = 1'b0;
        cpu_ce_i   = 1'b1;
        cpu_we_i   = 1'b0;
        cpu_addr_i = 16'h00AA;
        cpu_data_i = 16'h5555;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_stallreq", {31'h0, stallreq_o}, 0);
        chk("rst_ce_n", {31'h0, sram_ce_n_o}, 1);
        chk("rst_we_n", {31'h0, sram_we_n_o}, 1);
        chk("rst_oe_n", {31'h0, sram_oe_n_o}, 1);
        chk("rst_dq_oe", {31'h0, sram_dq_oe_o}, 0);
        chk("rst_cpu_data", {16'h0, cpu_data_o}, 0);
        chk("rst_sram_addr", {16'h0, sram_addr_o}, 0);
        chk("rst_sram_dq", {16'h0, sram_dq_o}, 0);
        @(posedge clk);
        #1;
        cpu_ce_i = 1'b0;
        rst      = 1'b1;
        free_at  = cyc;

        // Single read
        sram_mem[16'h0012]  = 16'hBEEF;
        model_mem[16'h0012] = 16'hBEEF;
        t = cyc;
        xact(1'b0, 16'h0012, 16'h0000, 1'b0);
        idle(W + 4);
        chk_trace("rd", t, 1'b0);
        chk("rd_hold", {16'h0, cpu_data_o}, 32'hBEEF);

        // Single write
        t = cyc;
        xact(1'b1, 16'h0034, 16'hA5A5, 1'b0);
        idle(W + 4);
        chk_trace("wr", t, 1'b1);
        chk("wr_sram_mem", {16'h0, sram_mem[16'h0034]}, 32'hA5A5);
        chk("wr_keeps_rdata", {16'h0, cpu_data_o}, 32'hBEEF);

        // Back-to-back write then read of the same word
        xact(1'b1, 16'h0005, 16'h1111, 1'b0);
        xact(1'b0, 16'h0005, 16'h0000, 1'b0);
        idle(2);
        chk("b2b_rdata", {16'h0, cpu_data_o}, 32'h1111);

        // Reset during the WE# pulse of a write
        issue(1'b1, 16'h0077, 16'h3C3C, acc, comp);
        @(posedge clk);
        #1;
        cpu_ce_i = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rstw_mid_we_n", {31'h0, sram_we_n_o}, 0);
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("rstw_we_n", {31'h0, sram_we_n_o}, 1);
        chk("rstw_ce_n", {31'h0, sram_ce_n_o}, 1);
        chk("rstw_dq_oe", {31'h0, sram_dq_oe_o}, 0);
        chk("rstw_stallreq", {31'h0, stallreq_o}, 0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        sb.delete();
        free_at = cyc;
        last_rd = 16'h0;
        xact(1'b0, 16'h0012, 16'h0000, 1'b0);
        xact(1'b1, 16'h0077, 16'h4D4D, 1'b0);
        xact(1'b0, 16'h0077, 16'h0000, 1'b0);
        idle(1);

        // Random traffic over a small window so reads hit recent writes
        repeat (300) begin
            we = 1'($urandom);
            a  = 16'h0100 + 16'($urandom_range(0, 15));
            d  = 16'($urandom);
            xact(we, a, d, 1'($urandom));
            if ($urandom_range(0, 3) == 0) idle(int'($urandom_range(1, 3)));
        end
        idle(W + 4);

        foreach (wr_addrs[i])
            chk($sformatf("mem_0x%0h", wr_addrs[i]), {16'h0, sram_mem[wr_addrs[i]]},
                {16'h0, model_mem[wr_addrs[i]]});
        chk("sb_drained", sb.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
